// File: rtl/idiv_arbiter_pkg.sv
// Shared definitions for the divider sharing controller: FSM encoding, op bits, slice helper.
// Latency: n/a. Backpressure: n/a.
package idiv_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam int OP_SIGNED = 0;
    localparam int OP_REM    = 1;
    localparam int OP_W      = 2;

    // Low bit of requester idx's slice in a flattened per-requester vector.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/idiv_arbiter_if.sv
// Requester and divider signal bundle; slave is the arbiter side, master the environment side.
// Latency: n/a. Backpressure: req_valid held until req_ready.
interface idiv_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic [NUM_REQ*2-1:0]          req_op;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [DATA_WIDTH-1:0]         resp_data;
    logic                          div_start;
    logic [DATA_WIDTH-1:0]         div_a;
    logic [DATA_WIDTH-1:0]         div_b;
    logic                          div_signed;
    logic [DATA_WIDTH-1:0]         div_quotient;
    logic [DATA_WIDTH-1:0]         div_remainder;
    logic                          div_done;

    modport slave (
        input  req_valid, req_a, req_b, req_op, div_quotient, div_remainder, div_done,
        output req_ready, resp_valid, resp_data, div_start, div_a, div_b, div_signed
    );

    modport master (
        output req_valid, req_a, req_b, req_op, div_quotient, div_remainder, div_done,
        input  req_ready, resp_valid, resp_data, div_start, div_a, div_b, div_signed
    );
endinterface

// File: rtl/idiv_rr_picker.sv
// Round-robin one-hot picker: first valid requester at or above ptr, with wrap.
// Latency: combinational. Backpressure: none.
module idiv_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int RR_W    = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [RR_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [RR_W-1:0]    idx,
    output logic               any
);
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && valid[(int'(ptr) + i) % NUM_REQ]) begin
                grant[(int'(ptr) + i) % NUM_REQ] = 1'b1;
                idx = RR_W'((int'(ptr) + i) % NUM_REQ);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/idiv_arbiter.sv
// Shares one multicycle divider among NUM_REQ requesters with a one-entry DIV/MOD result cache.
// Latency: hit resp 2 cycles after handshake, miss resp 1 cycle after div_done. Backpressure: one transaction in flight; req_ready only in IDLE.
module idiv_arbiter
    import idiv_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    idiv_arbiter_if.slave bus,
    input  logic          cache_flush,
    output logic          busy
);
    localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t                state, state_nxt;
    logic [RR_W-1:0]       rr_ptr, rr_nxt, owner, pick_idx;
    logic [NUM_REQ-1:0]    pick_grant;
    logic                  pick_any;
    logic [DATA_WIDTH-1:0] lat_a, lat_b, key_a, key_b, cache_q, cache_r, result;
    logic [DATA_WIDTH-1:0] div_a_q, div_b_q;
    logic [OP_W-1:0]       lat_op;
    logic                  key_signed, cache_valid, div_signed_q, hit;

    idiv_rr_picker #(.NUM_REQ(NUM_REQ), .RR_W(RR_W)) u_picker (
        .valid (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign rr_nxt = (pick_idx == RR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    assign hit    = cache_valid && !cache_flush && (key_a == lat_a) && (key_b == lat_b)
                    && (key_signed == lat_op[OP_SIGNED]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (pick_any) state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = hit ? ST_RESP : ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (bus.div_done) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign bus.req_ready  = (state == ST_IDLE) ? pick_grant : '0;
    assign bus.resp_valid = (state == ST_RESP) ? (NUM_REQ'(1) << owner) : '0;
    assign bus.resp_data  = (state == ST_RESP) ? result : '0;
    assign bus.div_start  = (state == ST_ISSUE);
    assign bus.div_a      = div_a_q;
    assign bus.div_b      = div_b_q;
    assign bus.div_signed = div_signed_q;
    assign busy           = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr       <= '0;
            owner        <= '0;
            lat_a        <= '0;
            lat_b        <= '0;
            lat_op       <= '0;
            div_a_q      <= '0;
            div_b_q      <= '0;
            div_signed_q <= 1'b0;
            result       <= '0;
            cache_valid  <= 1'b0;
            key_a        <= '0;
            key_b        <= '0;
            key_signed   <= 1'b0;
            cache_q      <= '0;
            cache_r      <= '0;
        end else begin
            if (state == ST_IDLE && pick_any) begin
                lat_a  <= bus.req_a[slice_lo(int'(pick_idx), DATA_WIDTH) +: DATA_WIDTH];
                lat_b  <= bus.req_b[slice_lo(int'(pick_idx), DATA_WIDTH) +: DATA_WIDTH];
                lat_op <= bus.req_op[slice_lo(int'(pick_idx), OP_W) +: OP_W];
                owner  <= pick_idx;
                rr_ptr <= rr_nxt;
            end
            if (state == ST_CHECK) begin
                if (hit) begin
                    result <= lat_op[OP_REM] ? cache_r : cache_q;
                end else begin
                    div_a_q      <= lat_a;
                    div_b_q      <= lat_b;
                    div_signed_q <= lat_op[OP_SIGNED];
                end
            end
            if (state == ST_WAIT && bus.div_done) begin
                cache_q    <= bus.div_quotient;
                cache_r    <= bus.div_remainder;
                key_a      <= lat_a;
                key_b      <= lat_b;
                key_signed <= lat_op[OP_SIGNED];
                result     <= lat_op[OP_REM] ? bus.div_remainder : bus.div_quotient;
            end
            // A flush coinciding with a capture leaves the cache empty; the response still goes out.
            if (cache_flush)                            cache_valid <= 1'b0;
            else if (state == ST_WAIT && bus.div_done)  cache_valid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_idiv_arbiter.sv
// Bench for idiv_arbiter with a behavioural divider and a cache/arith reference model.
`timescale 1ns/1ps
module tb_idiv_arbiter;
    localparam int DW = 32;
    localparam int NR = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic flush_reg = 1'b0;
    logic flush_on_done = 1'b0;
    logic cache_flush;
    logic busy;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int starts = 0;
    int div_lat_fix = 0;

    // Reference cache model: last key computed by the divider.
    bit          m_valid = 1'b0;
    logic [31:0] m_a, m_b;
    logic        m_s;

    idiv_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    idiv_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .cache_flush (cache_flush),
        .busy        (busy)
    );

    assign cache_flush = flush_reg | (flush_on_done & bus.div_done);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_q(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return $signed(a) / $signed(b);
        end
        return a / b;
    endfunction

    function automatic logic [31:0] ref_r(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (b == 32'd0) return a;
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return $signed(a) % $signed(b);
        end
        return a % b;
    endfunction

    // Behavioural divider with random latency; reset with the block.
    int dcnt = 0;
    logic [31:0] da, db;
    logic ds;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dcnt <= 0;
            bus.div_done <= 1'b0;
            bus.div_quotient <= '0;
            bus.div_remainder <= '0;
        end else begin
            bus.div_done <= 1'b0;
            if (dcnt > 1) dcnt <= dcnt - 1;
            else if (dcnt == 1) begin
                dcnt <= 0;
                bus.div_done <= 1'b1;
                bus.div_quotient <= ref_q(da, db, ds);
                bus.div_remainder <= ref_r(da, db, ds);
            end
            if (bus.div_start) begin
                starts <= starts + 1;
                da <= bus.div_a;
                db <= bus.div_b;
                ds <= bus.div_signed;
                dcnt <= (div_lat_fix > 0) ? div_lat_fix : int'($urandom_range(1, 4));
            end
        end
    end

    task automatic model_txn(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                             output bit hit, output logic [31:0] exp);
        hit = m_valid && m_a == a && m_b == b && m_s == op[0];
        exp = op[1] ? ref_r(a, b, op[0]) : ref_q(a, b, op[0]);
        if (!hit) begin
            m_valid = 1'b1; m_a = a; m_b = b; m_s = op[0];
        end
    endtask

    // One transaction on requester i; returns observations (data, resp vector, latencies, starts).
    task automatic do_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          output logic [31:0] data, output logic [NR-1:0] rv,
                          output int lat, output int dlat, output int nstart);
        int hs, done_c, st0;
        bit got;
        hs = -1; done_c = -1; got = 1'b0; data = '0; rv = '0; lat = -1; dlat = -1; nstart = -1;
        @(negedge clk);
        bus.req_a[i*DW +: DW] = a;
        bus.req_b[i*DW +: DW] = b;
        bus.req_op[i*2 +: 2]  = op;
        bus.req_valid[i]      = 1'b1;
        st0 = starts;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (bus.req_ready[i]) begin hs = cyc; break; end
            @(negedge clk);
        end
        if (hs < 0) begin
            checks++; failures++;
            $display("FAIL grant_timeout req=%0d got no req_ready, required a grant", i);
            bus.req_valid[i] = 1'b0;
            return;
        end
        @(negedge clk);
        bus.req_valid[i] = 1'b0;
        for (int k = 0; k < 200; k++) begin
            #1;
            if (bus.div_done) done_c = cyc;
            if (|bus.resp_valid) begin
                got = 1'b1; data = bus.resp_data; rv = bus.resp_valid; lat = cyc - hs;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL resp_timeout req=%0d got no resp_valid, required a response", i);
        end
        dlat = (done_c >= 0) ? (cyc - done_c) : -1;
        nstart = starts - st0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bus.req_ready !== '0) begin failures++; $display("FAIL rst_req_ready got=%b want=0", bus.req_ready); end
        checks++; if (bus.resp_valid !== '0) begin failures++; $display("FAIL rst_resp_valid got=%b want=0", bus.resp_valid); end
        checks++; if (bus.resp_data !== '0) begin failures++; $display("FAIL rst_resp_data got=%h want=0", bus.resp_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", busy); end
        checks++; if (bus.div_start !== 1'b0) begin failures++; $display("FAIL rst_div_start got=%b want=0", bus.div_start); end
        checks++; if (bus.div_a !== '0 || bus.div_b !== '0 || bus.div_signed !== 1'b0) begin
            failures++; $display("FAIL rst_div_ops got=%h/%h/%b want=0/0/0", bus.div_a, bus.div_b, bus.div_signed); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_divu_miss();
        logic [31:0] d; logic [NR-1:0] rv; int lat, dlat, ns;
        do_req(0, 32'd100, 32'd7, 2'b00, d, rv, lat, dlat, ns);
        checks++; if (d !== 32'd14 || rv !== 2'b01) begin failures++; $display("FAIL divu data=%h rv=%b want 14/01", d, rv); end
        checks++; if (ns != 1 || dlat != 1) begin failures++; $display("FAIL divu_timing starts=%0d done_to_resp=%0d want 1/1", ns, dlat); end
    endtask

    task automatic test_hit();
        logic [31:0] d; logic [NR-1:0] rv; int lat, dlat, ns;
        do_req(0, 32'd100, 32'd7, 2'b10, d, rv, lat, dlat, ns);
        checks++; if (d !== 32'd2 || rv !== 2'b01) begin failures++; $display("FAIL modu_hit data=%h rv=%b want 2/01", d, rv); end
        checks++; if (ns != 0 || lat != 2) begin failures++; $display("FAIL modu_hit_timing starts=%0d lat=%0d want 0/2", ns, lat); end
    endtask

    task automatic test_signed();
        logic [31:0] d; logic [NR-1:0] rv; int lat, dlat, ns;
        do_req(0, 32'hFFFF_FFF9, 32'd2, 2'b01, d, rv, lat, dlat, ns);
        checks++; if (d !== 32'hFFFF_FFFD || ns != 1) begin failures++; $display("FAIL sdiv data=%h starts=%0d want fffffffd/1", d, ns); end
        do_req(0, 32'hFFFF_FFF9, 32'd2, 2'b11, d, rv, lat, dlat, ns);
        checks++; if (d !== 32'hFFFF_FFFF || ns != 0 || lat != 2) begin
            failures++; $display("FAIL smod_hit data=%h starts=%0d lat=%0d want ffffffff/0/2", d, ns, lat); end
        do_req(0, 32'hFFFF_FFF9, 32'd2, 2'b10, d, rv, lat, dlat, ns);
        checks++; if (d !== 32'd1 || ns != 1) begin failures++; $display("FAIL umod_miss data=%h starts=%0d want 1/1", d, ns); end
    endtask

    task automatic test_div_zero();
        logic [31:0] d; logic [NR-1:0] rv; int lat, dlat, ns;
        do_req(0, 32'd5, 32'd0, 2'b00, d, rv, lat, dlat, ns);
        checks++; if (d !== 32'hFFFF_FFFF || ns != 1) begin failures++; $display("FAIL div0 data=%h starts=%0d want ffffffff/1", d, ns); end
        do_req(0, 32'd5, 32'd0, 2'b10, d, rv, lat, dlat, ns);
        checks++; if (d !== 32'd5 || ns != 0 || lat != 2) begin failures++; $display("FAIL mod0_hit data=%h starts=%0d lat=%0d want 5/0/2", d, ns, lat); end
        do_req(0, 32'h8000_0000, 32'hFFFF_FFFF, 2'b01, d, rv, lat, dlat, ns);
        checks++; if (d !== 32'h8000_0000) begin failures++; $display("FAIL sovf_q data=%h want 80000000", d); end
        do_req(0, 32'h8000_0000, 32'hFFFF_FFFF, 2'b11, d, rv, lat, dlat, ns);
        checks++; if (d !== 32'd0 || ns != 0) begin failures++; $display("FAIL sovf_r data=%h starts=%0d want 0/0", d, ns); end
    endtask

    // Both requesters held valid; last owner was 0 so the pointer starts at 1.
    task automatic test_round_robin();
        logic [31:0] exp_d [2];
        int g_exp, last_g, ngrant, nresp;
        exp_d[0] = 32'd100; exp_d[1] = 32'd2;
        g_exp = 1; last_g = -1; ngrant = 0; nresp = 0;
        @(negedge clk);
        bus.req_a = {32'd1001, 32'd1000};
        bus.req_b = {32'd9, 32'd10};
        bus.req_op = {2'b10, 2'b00};
        bus.req_valid = 2'b11;
        for (int k = 0; k < 400 && nresp < 4; k++) begin
            #1;
            if (|bus.resp_valid) begin
                checks++; nresp++;
                if (last_g < 0 || bus.resp_valid !== (2'b01 << last_g) || bus.resp_data !== exp_d[last_g]) begin
                    failures++; $display("FAIL rr_resp rv=%b data=%h owner=%0d", bus.resp_valid, bus.resp_data, last_g);
                end
            end
            if (|bus.req_ready && ngrant < 4) begin
                checks++; ngrant++;
                if (bus.req_ready !== (2'b01 << g_exp)) begin
                    failures++; $display("FAIL rr_grant got=%b want=%b", bus.req_ready, 2'b01 << g_exp);
                end
                last_g = bus.req_ready[1] ? 1 : 0;
                g_exp = 1 - last_g;
            end
            @(negedge clk);
            if (ngrant == 4) bus.req_valid = '0;
        end
        bus.req_valid = '0;
        checks++; if (nresp != 4) begin failures++; $display("FAIL rr_count resps=%0d want 4", nresp); end
    endtask

    task automatic test_flush();
        logic [31:0] d; logic [NR-1:0] rv; int lat, dlat, ns;
        do_req(0, 32'd50, 32'd6, 2'b00, d, rv, lat, dlat, ns);
        checks++; if (d !== 32'd8) begin failures++; $display("FAIL flush_div data=%h want 8", d); end
        @(negedge clk); flush_reg = 1'b1;
        @(negedge clk); flush_reg = 1'b0;
        do_req(0, 32'd50, 32'd6, 2'b10, d, rv, lat, dlat, ns);
        checks++; if (d !== 32'd2 || ns != 1) begin failures++; $display("FAIL flush_mod data=%h starts=%0d want 2/1", d, ns); end
        flush_on_done = 1'b1;
        do_req(1, 32'd60, 32'd7, 2'b00, d, rv, lat, dlat, ns);
        flush_on_done = 1'b0;
        checks++; if (d !== 32'd8 || rv !== 2'b10) begin failures++; $display("FAIL flush_capture data=%h rv=%b want 8/10", d, rv); end
        do_req(1, 32'd60, 32'd7, 2'b10, d, rv, lat, dlat, ns);
        checks++; if (d !== 32'd4 || ns != 1) begin failures++; $display("FAIL flush_capture_mod data=%h starts=%0d want 4/1", d, ns); end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] d; logic [NR-1:0] rv; int lat, dlat, ns;
        bit granted;
        granted = 1'b0;
        div_lat_fix = 20;
        @(negedge clk);
        bus.req_a[31:0] = 32'd77; bus.req_b[31:0] = 32'd5; bus.req_op[1:0] = 2'b00;
        bus.req_valid[0] = 1'b1;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (bus.req_ready[0]) begin granted = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk); bus.req_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (!granted || busy !== 1'b1) begin failures++; $display("FAIL rstw_pre granted=%0d busy=%b want 1/1", granted, busy); end
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || bus.resp_valid !== '0) begin
            failures++; $display("FAIL rstw_abort busy=%b rv=%b want 0/00", busy, bus.resp_valid); end
        @(negedge clk);
        reset_n = 1'b1;
        div_lat_fix = 0;
        do_req(1, 32'd77, 32'd5, 2'b10, d, rv, lat, dlat, ns);
        checks++; if (d !== 32'd2 || rv !== 2'b10 || ns != 1) begin
            failures++; $display("FAIL rstw_new data=%h rv=%b starts=%0d want 2/10/1", d, rv, ns); end
    endtask

    task automatic test_random();
        logic [31:0] d, a, b, exp; logic [NR-1:0] rv; int lat, dlat, ns, i;
        logic [1:0] op;
        bit hit;
        @(negedge clk); flush_reg = 1'b1;
        @(negedge clk); flush_reg = 1'b0;
        m_valid = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk); flush_reg = 1'b1;
                @(negedge clk); flush_reg = 1'b0;
                m_valid = 1'b0;
            end
            i = int'($urandom_range(0, 1));
            op = 2'($urandom_range(0, 3));
            if (m_valid && $urandom_range(0, 1) == 1) begin
                a = m_a; b = m_b;
            end else begin
                a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
                case ($urandom_range(0, 3))
                    0: b = 32'd0;
                    1: b = 32'($urandom_range(1, 20));
                    2: b = 32'hFFFF_FFFF;
                    default: b = $urandom;
                endcase
            end
            model_txn(a, b, op, hit, exp);
            do_req(i, a, b, op, d, rv, lat, dlat, ns);
            checks++;
            if (d !== exp || rv !== (2'b01 << i)) begin
                failures++; $display("FAIL rand_data n=%0d a=%h b=%h op=%b got=%h/%b want=%h/%b", n, a, b, op, d, rv, exp, 2'b01 << i);
            end
            checks++;
            if (hit ? (ns != 0 || lat != 2) : (ns != 1 || dlat != 1)) begin
                failures++; $display("FAIL rand_timing n=%0d hit=%0d starts=%0d lat=%0d done_to_resp=%0d", n, hit, ns, lat, dlat);
            end
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_op = '0;
        reset_n = 1'b0;
        test_reset();
        test_divu_miss();
        test_hit();
        test_signed();
        test_div_zero();
        test_round_robin();
        test_flush();
        test_reset_in_wait();
        test_random();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
